// File: rtl/pipe_arith_pkg.sv
// pipe_arith_pkg: shared definitions for the pipe_arith_vr pipeline.
//   - mode_e   : per-transaction operation select carried alongside the data
//   - widths   : stage payload widths derived from the operand width N
package pipe_arith_pkg;

    typedef enum logic [1:0] {
        MODE_ADD_MUL  = 2'd0,   // ((A+B)+(C-D)) * D
        MODE_SUB_MUL  = 2'd1,   // ((A+B)-(C-D)) * D
        MODE_ADD_PASS = 2'd2,   // ((A+B)+(C-D)) * 1
        MODE_PROD     = 2'd3    // (A+B) * (C-D)
    } mode_e;

    localparam int unsigned MODE_W    = 2;
    localparam int unsigned N_DEFAULT = 10;

    // Stage 1 payload: {x1, x2, D, mode}
    function automatic int unsigned s1_width(input int unsigned n);
        return 3 * n + MODE_W;
    endfunction

    // Stage 2 payload: {p, q}
    function automatic int unsigned s2_width(input int unsigned n);
        return 2 * n;
    endfunction

    localparam int unsigned S1_W_DEFAULT = 3 * N_DEFAULT + MODE_W;
    localparam int unsigned S2_W_DEFAULT = 2 * N_DEFAULT;

endpackage

// File: rtl/pipe_stage_vr.sv
// pipe_stage_vr: one pipeline stage register (payload + valid bit).
//   clk      rising-edge clock
//   rst      synchronous active-high reset; clears valid and payload
//   i_ready  this stage's ready term; when 1 the stage loads from upstream
//   i_valid  upstream valid bit (a 0 loads a bubble)
//   i_data   upstream payload
//   o_valid  registered valid bit
//   o_data   registered payload
module pipe_stage_vr #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_ready,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_ready) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_arith_vr.sv
// pipe_arith_vr: 3-stage arithmetic pipeline with valid/ready handshake.
//   Stage 1: x1 = A+B, x2 = C-D (mod 2^N), carries D and mode
//   Stage 2: operand pair (p, q) selected by mode
//   Stage 3: F = p*q, full 2N-bit product resized to OW
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; A, B, C, D, mode are the operands
//   out_valid/out_ready downstream handshake; F is the result
//   occ                 number of occupied stages (0..3)
module pipe_arith_vr
    import pipe_arith_pkg::*;
#(
    parameter int unsigned N  = 10,
    parameter int unsigned OW = 2 * N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    input  logic [N-1:0]  C,
    input  logic [N-1:0]  D,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] F,
    output logic [1:0]    occ
);

    localparam int unsigned S1W = s1_width(N);
    localparam int unsigned S2W = s2_width(N);

    // Ready chain: a stage may load when it is empty or everything
    // downstream of it is moving, so bubbles are squeezed out.
    logic w_v1, w_v2, w_v3;
    logic w_r1, w_r2, w_r3;

    assign w_r3     = !w_v3 | out_ready;
    assign w_r2     = !w_v2 | w_r3;
    assign w_r1     = !w_v1 | w_r2;
    assign in_ready = w_r1;

    // Stage 1
    logic [N-1:0]   w_x1_in, w_x2_in;
    logic [S1W-1:0] w_s1_d, w_s1_q;

    assign w_x1_in = A + B;
    assign w_x2_in = C - D;
    assign w_s1_d  = {w_x1_in, w_x2_in, D, mode};

    pipe_stage_vr #(.W(S1W)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .i_ready (w_r1),
        .i_valid (in_valid),
        .i_data  (w_s1_d),
        .o_valid (w_v1),
        .o_data  (w_s1_q)
    );

    logic [N-1:0] w_x1, w_x2, w_d1;
    mode_e        w_mode1;

    assign w_x1    = w_s1_q[S1W-1 -: N];
    assign w_x2    = w_s1_q[S1W-N-1 -: N];
    assign w_d1    = w_s1_q[MODE_W +: N];
    assign w_mode1 = mode_e'(w_s1_q[MODE_W-1:0]);

    // Stage 2 operand selection
    logic [N-1:0]   w_p_in, w_q_in;
    logic [S2W-1:0] w_s2_d, w_s2_q;

    always_comb begin
        w_p_in = w_x1 + w_x2;
        w_q_in = w_d1;
        case (w_mode1)
            MODE_ADD_MUL: begin
                w_p_in = w_x1 + w_x2;
                w_q_in = w_d1;
            end
            MODE_SUB_MUL: begin
                w_p_in = w_x1 - w_x2;
                w_q_in = w_d1;
            end
            MODE_ADD_PASS: begin
                w_p_in = w_x1 + w_x2;
                w_q_in = N'(1);
            end
            MODE_PROD: begin
                w_p_in = w_x1;
                w_q_in = w_x2;
            end
            default: begin
                w_p_in = w_x1 + w_x2;
                w_q_in = w_d1;
            end
        endcase
    end

    assign w_s2_d = {w_p_in, w_q_in};

    pipe_stage_vr #(.W(S2W)) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .i_ready (w_r2),
        .i_valid (w_v1),
        .i_data  (w_s2_d),
        .o_valid (w_v2),
        .o_data  (w_s2_q)
    );

    // Stage 3: full-width product, then truncate or zero-extend to OW
    logic [N-1:0]   w_p, w_q;
    logic [2*N-1:0] w_prod;
    logic [OW-1:0]  w_f_in;

    assign w_p    = w_s2_q[S2W-1 -: N];
    assign w_q    = w_s2_q[N-1:0];
    assign w_prod = {{N{1'b0}}, w_p} * {{N{1'b0}}, w_q};
    assign w_f_in = OW'(w_prod);

    pipe_stage_vr #(.W(OW)) u_stage3 (
        .clk     (clk),
        .rst     (rst),
        .i_ready (w_r3),
        .i_valid (w_v2),
        .i_data  (w_f_in),
        .o_valid (w_v3),
        .o_data  (F)
    );

    assign out_valid = w_v3;
    assign occ       = {1'b0, w_v1} + {1'b0, w_v2} + {1'b0, w_v3};

endmodule

// File: tb/tb_pipe_arith_vr.sv
// tb_pipe_arith_vr: self-checking bench for pipe_arith_vr (N=10, OW=20).
// The reference keeps a queue of in-flight items, each with its expected
// result and current stage position; items advance when there is a hole
// ahead of them or the consumer is taking data.
module tb_pipe_arith_vr;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  A, B, C, D;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] F;
    logic [1:0]  occ;

    pipe_arith_vr #(.N(10), .OW(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] f;
        int          pos;
    } item_t;

    item_t mq[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] ref_f(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d,
                                           input int unsigned m);
        longint unsigned x1, x2, p, q;
        x1 = (a + b) % 1024;
        x2 = (c + 1024 - d) % 1024;
        case (m)
            0: begin p = (x1 + x2) % 1024;        q = d;  end
            1: begin p = (x1 + 1024 - x2) % 1024; q = d;  end
            2: begin p = (x1 + x2) % 1024;        q = 1;  end
            default: begin p = x1;                q = x2; end
        endcase
        return 20'(p * q);
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, update model.
    task automatic cycle(input logic iv, input logic [9:0] a, input logic [9:0] b,
                         input logic [9:0] c, input logic [9:0] d, input logic [1:0] m,
                         input logic ordy);
        bit    exp_rdy, exp_ov, in_x;
        item_t nq[$];
        item_t it;
        in_valid  = iv;
        A = a; B = b; C = c; D = d;
        mode      = m;
        out_ready = ordy;
        #2;
        exp_rdy = (mq.size() < 3) || ordy;
        exp_ov  = (mq.size() > 0) && (mq[0].pos == 3);
        check_val("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        check_val("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
        if (exp_ov) check_val("F", 64'(F), 64'(mq[0].f));
        in_x = iv && exp_rdy;
        @(posedge clk);
        #1;
        foreach (mq[i]) begin
            it = mq[i];
            if (it.pos == 3) begin
                if (!ordy) nq.push_back(it);
            end else begin
                if ((i < 3 - it.pos) || ordy) it.pos++;
                nq.push_back(it);
            end
        end
        if (in_x) nq.push_back('{ref_f(a, b, c, d, m), 1});
        mq = nq;
        check_val("occ", 64'(occ), 64'(mq.size()));
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 2'd0, ordy);
    endtask

    task automatic rand_item(input logic ordy);
        logic [9:0] a, b, c, d;
        a = 10'($urandom_range(0, 1023));
        b = 10'($urandom_range(0, 1023));
        c = 10'($urandom_range(0, 1023));
        d = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 7) == 0) begin
            a = 10'd1023; c = 10'd0; d = 10'd1023;
        end
        cycle(1'b1, a, b, c, d, 2'($urandom_range(0, 3)), ordy);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        #1;
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_F", 64'(F), 64'd0);
        check_val("rst_occ", 64'(occ), 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    typedef struct {
        logic [9:0]  a, b, c, d;
        logic [1:0]  m;
        logic [19:0] f;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; C = '0; D = '0; mode = '0;

        vecs[0] = '{10'd5,    10'd3,  10'd9,    10'd2, 2'd0, 20'd30};
        vecs[1] = '{10'd5,    10'd3,  10'd9,    10'd2, 2'd1, 20'd2};
        vecs[2] = '{10'd5,    10'd3,  10'd9,    10'd2, 2'd2, 20'd15};
        vecs[3] = '{10'd5,    10'd3,  10'd9,    10'd2, 2'd3, 20'd56};
        vecs[4] = '{10'd1023, 10'd1,  10'd0,    10'd1, 2'd0, 20'd1023};
        vecs[5] = '{10'd1000, 10'd23, 10'd1023, 10'd0, 2'd3, 20'd1046529};

        do_reset();

        // Directed vectors: result appears after the third register load.
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].m, 1'b1);
            check_val("lat_ov_e1", {63'd0, out_valid}, 64'd0);
            idle(1'b1);
            check_val("lat_ov_e2", {63'd0, out_valid}, 64'd0);
            idle(1'b1);
            check_val("lat_ov_e3", {63'd0, out_valid}, 64'd1);
            check_val("vec_F", 64'(F), 64'(vecs[i].f));
            idle(1'b1);
        end

        // Back-to-back stream of 8 items.
        for (int k = 0; k < 8; k++) rand_item(1'b1);
        check_val("stream_occ", 64'(occ), 64'd3);
        for (int k = 0; k < 4; k++) idle(1'b1);

        // Backpressure with continuous input, then release.
        for (int k = 0; k < 5; k++) rand_item(1'b0);
        check_val("bp_occ", 64'(occ), 64'd3);
        check_val("bp_in_ready", {63'd0, in_ready}, 64'd0);
        for (int k = 0; k < 6; k++) rand_item(1'b1);
        for (int k = 0; k < 4; k++) idle(1'b1);

        // Bubble collapse: lone item runs to stage 3, then two more fill in.
        rand_item(1'b0);
        for (int k = 0; k < 3; k++) idle(1'b0);
        check_val("bub_occ1", 64'(occ), 64'd1);
        check_val("bub_ov", {63'd0, out_valid}, 64'd1);
        rand_item(1'b0);
        rand_item(1'b0);
        check_val("bub_occ3", 64'(occ), 64'd3);
        for (int k = 0; k < 4; k++) idle(1'b1);

        // Reset with a full pipeline; nothing stale may emerge afterwards.
        for (int k = 0; k < 3; k++) rand_item(1'b0);
        check_val("pre_rst_occ", 64'(occ), 64'd3);
        do_reset();
        for (int k = 0; k < 5; k++) idle(1'b1);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) < 7) rand_item(1'($urandom_range(0, 9) < 6));
            else idle(1'($urandom_range(0, 9) < 6));
        end

        // Bounded drain.
        for (int k = 0; k < 6; k++) idle(1'b1);
        check_val("drain_occ", 64'(occ), 64'd0);
        check_val("drain_ov", {63'd0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_arith_vr.md
Name: pipe_arith_vr

Overview:
- Parametrised 3-stage arithmetic pipeline; next generation of the fixed (A+B)+(C-D), then ×D datapath block.
- Adds per-transaction mode select and a valid/ready handshake with backpressure and bubble collapse.
- Adds a synchronous reset and a full-width product.
- Sits between an upstream operand producer and a downstream consumer; throughput 1 result/cycle when unstalled.

Parameters:
- N, 10, operand width; all stage-1/stage-2 arithmetic is modulo 2^N.
- OW, 2*N, output width; F is the product truncated or zero-extended to OW bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set on A/B/C/D/mode is valid.
- in_ready  out  1  pipeline can accept this cycle.
- A, B, C, D  in  N  unsigned operands.
- mode  in  2  operation select; travels with its data.
- out_valid  out  1  F holds a valid result.
- out_ready  in  1  consumer accepts F this cycle.
- F  out  OW  result.
- occ  out  2  number of occupied stages, 0..3.

Behaviour:
- Reset: when rst is high at a clk edge, all stage valid bits are cleared and all data registers, including F, go to 0.
  - Result: out_valid=0, occ=0, F=0; in_ready=1 the cycle after reset.
  - Reset mid-operation discards every in-flight item with no partial output.
- Stage 1 registers: x1=(A+B) mod 2^N, x2=(C-D) mod 2^N, D, mode, v1.
- Stage 2 registers the operand pair (p,q) and v2:
  - mode0: p=(x1+x2) mod 2^N, q=D.
  - mode1: p=(x1-x2) mod 2^N, q=D.
  - mode2: p=(x1+x2) mod 2^N, q=1.
  - mode3: p=x1, q=x2.
- Stage 3 registers F = p*q (2N-bit unsigned product, truncated/zero-extended to OW) and v3; out_valid=v3.
- Handshake, combinational ready chain:
  - r3 = !v3 | out_ready; r2 = !v2 | r3; r1 = !v1 | r2; in_ready = r1.
  - Stage k loads from stage k-1 when rk=1; the loaded valid bit equals the upstream valid bit (bubbles propagate as v=0).
  - Stage 1 loads in_valid & in_ready.
  - A stage with rk=0 holds its data and valid bit unchanged.
- Transfer rules:
  - An input transfer occurs on in_valid & in_ready at the clk edge; an output transfer occurs on out_valid & out_ready.
  - in_ready may depend combinationally on out_ready.
  - in_valid must not depend on in_ready.
- Latency: a transfer accepted at edge t gives out_valid=1 after edge t+2, i.e. the item is the third register load, if there is no stall.
- Stall: while out_valid=1 and out_ready=0, F and out_valid stay stable.
  - Bubbles upstream collapse.
  - in_ready drops only when all 3 stages are valid.
- Simultaneous events:
  - With a full pipeline and out_ready=1, an input is accepted in the same cycle as the output drains; occ stays 3.
  - rst has priority over every transfer.
- occ = v1+v2+v3, registered state, updated each edge.
- Order is strictly preserved; no item is dropped or duplicated.
- Wrap-around: all sums and differences wrap modulo 2^N with no saturation or flags; the product never overflows at OW=2N.
- With OW=N and mode0, F equals the legacy block's N-bit output.

Decomposition:
- Shared package pipe_arith_pkg:
  - mode encodings MODE_ADD_MUL=2'd0, MODE_SUB_MUL=2'd1, MODE_ADD_PASS=2'd2, MODE_PROD=2'd3.
  - stage payload struct widths as localparams derived from N.
- One natural sub-module, pipe_stage_vr: a generic payload register plus valid bit with the rk load rule.
  - Instantiated 3 times with different payload widths.
  - The arithmetic stays in the top level.

Test Plan:
- N=10, mode0, A=5, B=3, C=9, D=2, out_ready=1 -> F=30, out_valid high 3 edges after accept; mode1 same operands -> F=2; mode2 -> F=15; mode3 -> F=56.
- Wrap: mode0, A=1023, B=1, C=0, D=1 -> x1=0, x2=1023, F=1023; mode3, A=1000, B=23, C=1023, D=0 -> F=1023*1023=1046529.
- Back-to-back stream of 8 items at in_valid=1 with out_ready=1 -> one result per cycle, in order, in_ready constantly 1, occ=3 at steady state.
- Backpressure: out_ready=0 for 5 cycles with continuous input:
  - -> in_ready falls after 3 accepts, F is stable, occ=3.
  - On release -> the 3 held results emerge in order, then the stream resumes with no loss.
- Bubble collapse: one item, then in_valid=0, out_ready=0 -> the item reaches stage 3 with occ=1 and in_ready=1; two further items are accepted while stalled, giving occ=3.
- Reset mid-flight with occ=3 -> after the rst edge out_valid=0, F=0, occ=0, in_ready=1; no stale result appears later.
